// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed N-digit hex seven-segment scanner.
// Holds N hex nibbles in a tear-free shadow register and scans them one digit
// per PRESCALE-cycle slot. New data is accepted into a pending register on
// 'load' and is committed to the shadow only at the frame boundary.
// Optional feature macro: SEG7_SCAN_DP_EN adds a per-digit decimal point
// (input dp, output dp_out) that travels through pending/shadow with the data.
//
// Update-handshake FSM:
//   state   | meaning
//   ST_IDLE | shadow holds the latest data, nothing waiting
//   ST_PEND | pending holds newer data, committed at the next frame wrap

module seg7_scan_mux #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     blank,
    input  logic                    load,
`ifdef SEG7_SCAN_DP_EN
    input  logic [N_DIGITS-1:0]     dp,
    output logic                    dp_out,
`endif
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [PW-1:0]           r_pcnt;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_pending;
    logic [4*N_DIGITS-1:0]   r_shadow;
    logic                    r_wrapped;

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_busy;
    logic [3:0]              w_nib;
    logic                    w_blank;
    logic [N_DIGITS-1:0]     w_an;
    logic [6:0]              w_seg;

`ifdef SEG7_SCAN_DP_EN
    logic [N_DIGITS-1:0]     r_pend_dp;
    logic [N_DIGITS-1:0]     r_shadow_dp;
    logic                    w_dp;
`endif

    // Full hex 0-F decode, bit0 = a ... bit6 = g.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    assign w_tick = (r_pcnt == PCNT_LAST);
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    // Slot prescaler: counts 0..PRESCALE-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PW'(1);
        end
    end

    // Digit index advances once per slot and wraps at the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_wrap) begin
            r_idx <= '0;
        end else if (w_tick) begin
            r_idx <= r_idx + IW'(1);
        end
    end

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake next state: a load on the wrap cycle bypasses pending entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (load && !w_wrap) w_state_nxt = ST_PEND;
            ST_PEND: if (w_wrap)          w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        w_busy = (r_state == ST_PEND);
    end

    assign busy = w_busy;

    // Pending capture (last load wins) and shadow commit aligned with the idx wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_shadow  <= '0;
        end else begin
            if (load) begin
                r_pending <= data;
            end
            if (w_wrap && load) begin
                r_shadow <= data;
            end else if (w_wrap && w_busy) begin
                r_shadow <= r_pending;
            end
        end
    end

`ifdef SEG7_SCAN_DP_EN
    // Decimal points follow exactly the same pending/shadow path as the nibbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_dp   <= '0;
            r_shadow_dp <= '0;
        end else begin
            if (load) begin
                r_pend_dp <= dp;
            end
            if (w_wrap && load) begin
                r_shadow_dp <= dp;
            end else if (w_wrap && w_busy) begin
                r_shadow_dp <= r_pend_dp;
            end
        end
    end
`endif

    // Select the current digit's nibble, blank bit and one-hot anode.
    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_an    = '0;
`ifdef SEG7_SCAN_DP_EN
        w_dp    = 1'b0;
`endif
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nib   = r_shadow[4*i +: 4];
                w_blank = blank[i];
                w_an[i] = 1'b1;
`ifdef SEG7_SCAN_DP_EN
                w_dp    = r_shadow_dp[i];
`endif
            end
        end
        w_seg = hex_decode(w_nib);
        if (w_blank) begin
            w_an  = '0;
            w_seg = 7'h00;
`ifdef SEG7_SCAN_DP_EN
            w_dp  = 1'b0;
`endif
        end
    end

    // Remember the wrap so frame_done lines up with the first digit-0 output cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrapped <= 1'b0;
        end else begin
            r_wrapped <= w_wrap;
        end
    end

    // Registered display outputs, one cycle behind idx/shadow/blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '0;
            seg        <= '0;
            frame_done <= 1'b0;
        end else begin
            an         <= w_an;
            seg        <= w_seg;
            frame_done <= r_wrapped;
        end
    end

`ifdef SEG7_SCAN_DP_EN
    // Registered decimal point, aligned with an/seg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_out <= 1'b0;
        end else begin
            dp_out <= w_dp;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux: N=4/PRESCALE=3 main instance plus a
// N=2/PRESCALE=1 instance for the tick-every-cycle case.
// Honours SEG7_SCAN_DP_EN for the decimal-point ports.

module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0000;
    logic [3:0]  blank = 4'b0000;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;
    logic        frame_done;

    logic [7:0]  data2 = 8'h00;
    logic [1:0]  blank2 = 2'b00;
    logic        load2 = 1'b0;
    logic [6:0]  seg2;
    logic [1:0]  an2;
    logic        busy2;
    logic        frame_done2;

`ifdef SEG7_SCAN_DP_EN
    logic [3:0]  dp = 4'b0000;
    logic        dp_out;
    logic [1:0]  dp2 = 2'b00;
    logic        dp_out2;
`endif

    int total = 0;
    int bad   = 0;
    int k     = 0;

    seg7_scan_mux #(.N_DIGITS(4), .PRESCALE(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .blank      (blank),
        .load       (load),
`ifdef SEG7_SCAN_DP_EN
        .dp         (dp),
        .dp_out     (dp_out),
`endif
        .seg        (seg),
        .an         (an),
        .busy       (busy),
        .frame_done (frame_done)
    );

    seg7_scan_mux #(.N_DIGITS(2), .PRESCALE(1)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .data       (data2),
        .blank      (blank2),
        .load       (load2),
`ifdef SEG7_SCAN_DP_EN
        .dp         (dp2),
        .dp_out     (dp_out2),
`endif
        .seg        (seg2),
        .an         (an2),
        .busy       (busy2),
        .frame_done (frame_done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    // Advance to the falling edge after the target-th rising edge since reset release.
    task automatic go_to(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_an", 32'(an), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_an2", 32'(an2), 32'h0);
        rst = 1'b0;
        k = 0;

        // Scan with all-zero data: 3 cycles per digit, frame every 12
        for (int kk = 1; kk <= 25; kk++) begin
            go_to(kk);
            chk("scan_an", 32'(an), 32'(1 << (((kk - 1) / 3) % 4)));
            chk("scan_seg", 32'(seg), 32'h3F);
            chk("scan_fd", 32'(frame_done), ((kk > 1) && ((kk - 1) % 12 == 0)) ? 32'h1 : 32'h0);
        end

        // Tear-free load during the digit-1 slot
        go_to(27);
        load = 1'b1;
        data = 16'hA5F1;
`ifdef SEG7_SCAN_DP_EN
        dp = 4'b0010;
`endif
        go_to(28);
        load = 1'b0;
        data = 16'h1234;
`ifdef SEG7_SCAN_DP_EN
        dp = 4'b0000;
`endif
        chk("load_busy", 32'(busy), 32'h1);
        chk("load_seg_hold", 32'(seg), 32'h3F);
        go_to(35);
        chk("load_busy_pre", 32'(busy), 32'h1);
        chk("load_seg_pre", 32'(seg), 32'h3F);
        go_to(36);
        chk("load_busy_fall", 32'(busy), 32'h0);
        go_to(37);
        chk("new_d0_an", 32'(an), 32'h1);
        chk("new_d0_seg", 32'(seg), 32'h06);
        chk("new_fd", 32'(frame_done), 32'h1);
`ifdef SEG7_SCAN_DP_EN
        chk("dp_d0", 32'(dp_out), 32'h0);
`endif
        go_to(40);
        chk("new_d1_seg", 32'(seg), 32'h71);
        chk("new_busy", 32'(busy), 32'h0);
`ifdef SEG7_SCAN_DP_EN
        chk("dp_d1", 32'(dp_out), 32'h1);
`endif
        go_to(43);
        chk("new_d2_seg", 32'(seg), 32'h6D);
`ifdef SEG7_SCAN_DP_EN
        chk("dp_d2", 32'(dp_out), 32'h0);
`endif
        go_to(46);
        chk("new_d3_seg", 32'(seg), 32'h77);
        chk("new_d3_an", 32'(an), 32'h8);

        // Load on the wrapping tick cycle goes straight to the shadow
        go_to(47);
        load = 1'b1;
        data = 16'h0008;
        go_to(48);
        load = 1'b0;
        chk("bnd_busy0", 32'(busy), 32'h0);
        go_to(49);
        chk("bnd_busy1", 32'(busy), 32'h0);
        chk("bnd_d0_an", 32'(an), 32'h1);
        chk("bnd_d0_seg", 32'(seg), 32'h7F);

        // Blank digit 2 only
        blank = 4'b0100;
        go_to(53);
        chk("blk_d1_an", 32'(an), 32'h2);
        chk("blk_d1_seg", 32'(seg), 32'h3F);
        go_to(55);
        chk("blk_d2_an", 32'(an), 32'h0);
        chk("blk_d2_seg", 32'(seg), 32'h00);
        go_to(57);
        chk("blk_d2_an_end", 32'(an), 32'h0);
        go_to(58);
        chk("blk_d3_an", 32'(an), 32'h8);
        chk("blk_d3_seg", 32'(seg), 32'h3F);
        blank = 4'b0000;

        // Async reset mid-slot with data pending
        load = 1'b1;
        data = 16'hFFFF;
        go_to(59);
        load = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        go_to(60);
        #2 rst = 1'b1;
        #1;
        chk("arst_an", 32'(an), 32'h0);
        chk("arst_seg", 32'(seg), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        load2 = 1'b1;
        data2 = 8'h21;
        k = 0;

        // Restart at digit 0; the N=2/PRESCALE=1 instance advances every cycle
        go_to(1);
        load2 = 1'b0;
        chk("restart_an", 32'(an), 32'h1);
        chk("restart_seg", 32'(seg), 32'h3F);
        chk("p1_an_k1", 32'(an2), 32'h1);
        chk("p1_seg_k1", 32'(seg2), 32'h3F);
        chk("p1_busy_k1", 32'(busy2), 32'h1);
        go_to(2);
        chk("p1_an_k2", 32'(an2), 32'h2);
        chk("p1_busy_k2", 32'(busy2), 32'h0);
        chk("p1_fd_k2", 32'(frame_done2), 32'h0);
        go_to(3);
        chk("p1_an_k3", 32'(an2), 32'h1);
        chk("p1_seg_k3", 32'(seg2), 32'h06);
        chk("p1_fd_k3", 32'(frame_done2), 32'h1);
        go_to(4);
        chk("p1_an_k4", 32'(an2), 32'h2);
        chk("p1_seg_k4", 32'(seg2), 32'h5B);
        chk("p1_fd_k4", 32'(frame_done2), 32'h0);
        chk("restart_d1_an", 32'(an), 32'h2);
        chk("restart_d1_seg", 32'(seg), 32'h3F);
        go_to(13);
        chk("restart_wrap_seg", 32'(seg), 32'h3F);
        chk("restart_wrap_fd", 32'(frame_done), 32'h1);
        chk("restart_wrap_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
